// File: rtl/data_compare4.sv
// Cascadable magnitude comparator (74x85 style) with a one-hot {gt,eq,lt} result registered once.
// Define DATA_COMPARE4_SIGNED_EN to compare a and b as two's-complement values instead of unsigned.
module data_compare4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       comp,
  output logic [2:0]       o
);

  // Equal operands defer to the lower stage; gt outranks lt, and an empty or
  // eq-only cascade both resolve to eq so the output stays one-hot.
  function automatic logic [2:0] resolve_cascade(input logic [2:0] c);
    logic [2:0] res;
    if (c[2]) begin
      res = 3'b100;
    end else if (c[0]) begin
      res = 3'b001;
    end else begin
      res = 3'b010;
    end
    return res;
  endfunction

  logic       gt_s;
  logic       lt_s;
  logic [2:0] r_s;
  logic [2:0] o_r;

  // Magnitude compare of the operands in the configured number representation.
  always_comb begin
`ifdef DATA_COMPARE4_SIGNED_EN
    gt_s = ($signed(a) > $signed(b));
    lt_s = ($signed(a) < $signed(b));
`else
    gt_s = (a > b);
    lt_s = (a < b);
`endif
  end

  // Select the local verdict or the resolved cascade value.
  always_comb begin
    r_s = 3'b000;
    case ({gt_s, lt_s})
      2'b10:   r_s = 3'b100;
      2'b01:   r_s = 3'b001;
      2'b00:   r_s = resolve_cascade(comp);
      default: r_s = 3'b010;
    endcase
  end

  // Result register; reset clears it immediately without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_r <= 3'b000;
    end else begin
      o_r <= r_s;
    end
  end

  assign o = o_r;

endmodule

// File: tb/tb_data_compare4.sv
// Randomized self-checking bench for data_compare4 against an integer-arithmetic reference model.
module tb_data_compare4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       comp;
  logic [2:0]       o;

  int n_checks;
  int n_pass;

  data_compare4 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .comp (comp),
    .o    (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (a=%0d b=%0d comp=%b)", tag, obs, exp, a, b, comp);
    end
  endtask

  // Operand value as the design should interpret it.
  function automatic int op_value(input logic [WIDTH-1:0] v);
    int x;
    x = int'(v);
`ifdef DATA_COMPARE4_SIGNED_EN
    if (x >= (1 << (WIDTH - 1))) x = x - (1 << WIDTH);
`endif
    return x;
  endfunction

  function automatic logic [2:0] ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                           input logic [2:0] rc);
    int va;
    int vb;
    va = op_value(ra);
    vb = op_value(rb);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b001;
    if (rc[2]) return 3'b100;
    if (rc[0]) return 3'b001;
    return 3'b010;
  endfunction

  // Drive on the falling edge, check one cycle later just after the rising edge.
  task automatic apply(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [2:0] tc, input logic [2:0] exp);
    @(negedge clk);
    a = ta;
    b = tb;
    comp = tc;
    @(posedge clk);
    #1;
    check_eq(tag, o, exp);
  endtask

  logic [2:0] signed_exp;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b1;
    a = 4'd5;
    b = 4'd3;
    comp = 3'b010;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_async", o, 3'b000);
    @(posedge clk);
    #1;
    check_eq("reset_hold", o, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_release", o, 3'b100);

    apply("casc_lt", 4'd0, 4'd0, 3'b001, 3'b001);
    apply("casc_eq", 4'd0, 4'd0, 3'b010, 3'b010);
    apply("casc_gt", 4'd0, 4'd0, 3'b100, 3'b100);
    apply("ne_gt", 4'b0010, 4'b0000, 3'b010, 3'b100);
    apply("ne_lt", 4'b1000, 4'b1100, 3'b010, 3'b001);
    apply("inv_000", 4'b0110, 4'b0110, 3'b000, 3'b010);
    apply("inv_111", 4'b0110, 4'b0110, 3'b111, 3'b100);
    apply("inv_011", 4'b0110, 4'b0110, 3'b011, 3'b001);
    apply("max_vs_0", 4'b1111, 4'b0000, 3'b001, ref_model(4'b1111, 4'b0000, 3'b001));
`ifdef DATA_COMPARE4_SIGNED_EN
    signed_exp = 3'b001;
`else
    signed_exp = 3'b100;
`endif
    apply("sign_8v7", 4'b1000, 4'b0111, 3'b010, signed_exp);

    // Mid-cycle reset while the output holds gt.
    apply("pre_mid_rst", 4'd5, 4'd3, 3'b010, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_async", o, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic [2:0]       rc;
      ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rb = (($urandom_range(0, 3)) == 0) ? ra : WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rc = 3'($urandom_range(0, 7));
      apply("random", ra, rb, rc, ref_model(ra, rb, rc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
